// File: rtl/router_pkg.sv
// Shared router definitions: direction one-hots, port indices, arbiter states
// and small index helpers used by the output arbiters.
package router_pkg;

  localparam logic [4:0] DIR_L  = 5'b10000;
  localparam logic [4:0] DIR_R  = 5'b01000;
  localparam logic [4:0] DIR_U  = 5'b00100;
  localparam logic [4:0] DIR_D  = 5'b00010;
  localparam logic [4:0] DIR_PE = 5'b00001;

  localparam logic [2:0] IDX_L  = 3'd4;
  localparam logic [2:0] IDX_R  = 3'd3;
  localparam logic [2:0] IDX_U  = 3'd2;
  localparam logic [2:0] IDX_D  = 3'd1;
  localparam logic [2:0] IDX_PE = 3'd0;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_SEND    = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_t;

  // Index of the set bit of a one-hot port vector (0 when empty).
  function automatic logic [2:0] onehot_to_idx(input logic [4:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Round-robin successor of a port index, wrapping L back to PE.
  function automatic logic [2:0] next_ptr(input logic [2:0] idx);
    return (idx >= IDX_L) ? IDX_PE : idx + 3'd1;
  endfunction

endpackage

// File: rtl/rr_pick5.sv
// Combinational five-way round-robin picker: first set request at or after ptr,
// searching upward and wrapping 4 -> 0.
module rr_pick5 (
  input  logic [4:0] req_eff,
  input  logic [2:0] ptr,
  output logic [4:0] winner,
  output logic [2:0] winner_idx,
  output logic       any
);

  // Scan five positions starting at ptr; the first hit wins.
  always_comb begin
    int unsigned base;
    int unsigned j;
    logic        found;
    winner     = '0;
    winner_idx = '0;
    found      = 1'b0;
    base       = (ptr > 3'd4) ? 0 : 32'(ptr);
    for (int unsigned i = 0; i < 5; i++) begin
      j = base + i;
      if (j >= 5) j = j - 5;
      if (!found && req_eff[j[2:0]]) begin
        found      = 1'b1;
        winner_idx = j[2:0];
        winner     = 5'b00001 << j[2:0];
      end
    end
    any = found;
  end

endmodule

// File: rtl/output_arbiter.sv
// Per-output-direction scheduler: round-robin grant among the five input ports
// (own direction masked), registered flit with so/ro handshake, and a one-cycle
// buf_clear release pulse. Optional stall watchdog under OUTARB_TIMEOUT_EN.
module output_arbiter
  import router_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter logic [4:0]  DIRECTION      = DIR_L,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            req,
  input  logic [DATA_WIDTH-1:0] dataL,
  input  logic [DATA_WIDTH-1:0] dataR,
  input  logic [DATA_WIDTH-1:0] dataU,
  input  logic [DATA_WIDTH-1:0] dataD,
  input  logic [DATA_WIDTH-1:0] dataPE,
  input  logic                  ro,
  output logic                  so,
  output logic [DATA_WIDTH-1:0] datao,
  output logic [4:0]            buf_clear,
  output logic [4:0]            grant
`ifdef OUTARB_TIMEOUT_EN
  ,
  output logic                  timeout_err
`endif
);

  arb_state_t            state, state_nx;
  logic [2:0]            ptr, ptr_nx;
  logic                  so_nx;
  logic [DATA_WIDTH-1:0] datao_nx;
  logic [4:0]            buf_clear_nx;
  logic [4:0]            grant_nx;

  logic [4:0]            req_eff;
  logic [4:0]            win;
  logic [2:0]            win_idx;
  logic                  any;
  logic [DATA_WIDTH-1:0] win_data;

  assign req_eff = req & ~DIRECTION;

  rr_pick5 u_pick (
    .req_eff    (req_eff),
    .ptr        (ptr),
    .winner     (win),
    .winner_idx (win_idx),
    .any        (any)
  );

  // Select the flit of the arbitration winner.
  always_comb begin
    unique case (win_idx)
      IDX_L:   win_data = dataL;
      IDX_R:   win_data = dataR;
      IDX_U:   win_data = dataU;
      IDX_D:   win_data = dataD;
      default: win_data = dataPE;
    endcase
  end

  // Next-state and registered-output values for the grant/send/release cycle.
  always_comb begin
    state_nx     = state;
    ptr_nx       = ptr;
    so_nx        = so;
    datao_nx     = datao;
    buf_clear_nx = '0;
    grant_nx     = grant;
    unique case (state)
      ARB_IDLE: begin
        if (any) begin
          datao_nx = win_data;
          grant_nx = win;
          so_nx    = 1'b1;
          state_nx = ARB_SEND;
        end
      end
      ARB_SEND: begin
        if (so && ro) begin
          so_nx        = 1'b0;
          buf_clear_nx = grant;
          ptr_nx       = next_ptr(onehot_to_idx(grant));
          state_nx     = ARB_RELEASE;
        end
      end
      ARB_RELEASE: begin
        grant_nx = '0;
        state_nx = ARB_IDLE;
      end
      default: begin
        so_nx    = 1'b0;
        grant_nx = '0;
        state_nx = ARB_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any transfer in flight without a release pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      ptr       <= IDX_PE;
      so        <= 1'b0;
      datao     <= '0;
      buf_clear <= '0;
      grant     <= '0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      so        <= so_nx;
      datao     <= datao_nx;
      buf_clear <= buf_clear_nx;
      grant     <= grant_nx;
    end
  end

`ifdef OUTARB_TIMEOUT_EN
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] stall_cnt;
  logic [7:0] stall_inc;

  assign stall_inc = (stall_cnt == 8'hFF) ? stall_cnt : stall_cnt + 8'd1;

  // Count stalled SEND cycles; flag is sticky until reset and never blocks arbitration.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
    end else if (state == ARB_IDLE && any) begin
      stall_cnt <= '0;
    end else if (state == ARB_SEND && !ro) begin
      stall_cnt <= stall_inc;
      if (stall_inc == TO_LIMIT) timeout_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_output_arbiter.sv
// Directed bench for output_arbiter with a grant/flit scoreboard.
module tb_output_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  req, req2;
  logic [63:0] dL, dR, dU, dD, dPE;
  logic        ro, ro2;
  logic        so, so2;
  logic [63:0] datao, datao2;
  logic [4:0]  buf_clear, buf_clear2;
  logic [4:0]  grant, grant2;
`ifdef OUTARB_TIMEOUT_EN
  logic        terr, terr2;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [4:0]  g;
    logic [63:0] d;
  } sb_t;

  sb_t        sb_q[$];
  sb_t        exp_item;
  logic       so_q   = 1'b0;
  logic [4:0] last_g = '0;

  always #5 clk = ~clk;

  output_arbiter #(
    .DATA_WIDTH     (64),
    .DIRECTION      (5'b10000),
    .TIMEOUT_CYCLES (4)
  ) u_dut (
    .clk (clk), .rst (rst), .req (req),
    .dataL (dL), .dataR (dR), .dataU (dU), .dataD (dD), .dataPE (dPE),
    .ro (ro), .so (so), .datao (datao), .buf_clear (buf_clear), .grant (grant)
`ifdef OUTARB_TIMEOUT_EN
    , .timeout_err (terr)
`endif
  );

  output_arbiter #(
    .DATA_WIDTH     (64),
    .DIRECTION      (5'b00100),
    .TIMEOUT_CYCLES (255)
  ) u_uturn (
    .clk (clk), .rst (rst), .req (req2),
    .dataL (dL), .dataR (dR), .dataU (dU), .dataD (dD), .dataPE (dPE),
    .ro (ro2), .so (so2), .datao (datao2), .buf_clear (buf_clear2), .grant (grant2)
`ifdef OUTARB_TIMEOUT_EN
    , .timeout_err (terr2)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] data_of(input int unsigned idx);
    case (idx)
      4:       return dL;
      3:       return dR;
      2:       return dU;
      1:       return dD;
      default: return dPE;
    endcase
  endfunction

  function automatic sb_t mk(input int unsigned idx);
    sb_t s;
    s.g = 5'b00001 << idx;
    s.d = data_of(idx);
    return s;
  endfunction

  // Scoreboard: each rising so must carry the next expected owner and flit;
  // every buf_clear pulse must name the owner of the flit just sent.
  always @(negedge clk) begin
    if (so && !so_q) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_so", 64'(sb_q.size()), 64'd1);
      end else begin
        exp_item = sb_q.pop_front();
        chk("sb_grant", 64'(grant), 64'(exp_item.g));
        chk("sb_datao", datao, exp_item.d);
        last_g = exp_item.g;
      end
    end
    if (buf_clear != '0) chk("sb_buf_clear", 64'(buf_clear), 64'(last_g));
    so_q = so;
  end

  initial begin
    int unsigned rot_idx[5];
    rot_idx = '{1, 2, 3, 0, 1};
    rst = 1'b1; req = '0; req2 = '0; ro = 1'b0; ro2 = 1'b1;
    dL = 64'h4C4C_0000_0000_0010; dR = 64'h5252_0000_0000_0008;
    dU = 64'hA5; dD = 64'h4444_0000_0000_0002; dPE = 64'h5045_0000_0000_0001;
    step(); step();
    rst = 1'b0;

    // Reset state
    chk("rst_so", 64'(so), 64'd0);
    chk("rst_datao", datao, 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_buf_clear", 64'(buf_clear), 64'd0);
`ifdef OUTARB_TIMEOUT_EN
    chk("rst_timeout", 64'(terr), 64'd0);
`endif

    // Single request from U with ro high
    req = 5'b00100; ro = 1'b1;
    sb_q.push_back(mk(2));
    step();
    chk("single_so", 64'(so), 64'd1);
    chk("single_datao", datao, 64'hA5);
    chk("single_grant", 64'(grant), 64'b00100);
    step();
    chk("single_bc", 64'(buf_clear), 64'b00100);
    chk("single_so_drop", 64'(so), 64'd0);
    req = '0;
    step();
    chk("single_bc_one_cycle", 64'(buf_clear), 64'd0);
    chk("single_grant_idle", 64'(grant), 64'd0);

    // Backpressure on PE (ptr is at R, L masked, so PE wins); owner req drops at once
    req = 5'b00001; ro = 1'b0;
    sb_q.push_back(mk(0));
    step();
    req = '0;
    chk("bp_grant", 64'(grant), 64'b00001);
    chk("bp_so", 64'(so), 64'd1);
`ifdef OUTARB_TIMEOUT_EN
    chk("bp_timeout_0", 64'(terr), 64'd0);
`endif
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("bp_so_hold", 64'(so), 64'd1);
      chk("bp_datao_hold", datao, dPE);
      chk("bp_no_bc", 64'(buf_clear), 64'd0);
`ifdef OUTARB_TIMEOUT_EN
      chk("bp_timeout", 64'(terr), (k >= 4) ? 64'd1 : 64'd0);
`endif
    end
    ro = 1'b1;
    step();
    chk("bp_bc", 64'(buf_clear), 64'b00001);
    chk("bp_so_drop", 64'(so), 64'd0);
    step();
    chk("bp_grant_idle", 64'(grant), 64'd0);
`ifdef OUTARB_TIMEOUT_EN
    chk("bp_timeout_sticky", 64'(terr), 64'd1);
`endif

    // Rotation with D,U,R,PE held (L also requested later is masked anyway)
    req = 5'b01111;
    foreach (rot_idx[k]) sb_q.push_back(mk(rot_idx[k]));
    foreach (rot_idx[k]) begin
      step();
      chk("rot_grant", 64'(grant), 64'(5'b00001 << rot_idx[k]));
      chk("rot_so", 64'(so), 64'd1);
      step();
      chk("rot_bc", 64'(buf_clear), 64'(5'b00001 << rot_idx[k]));
      step();
      chk("rot_release", 64'(grant), 64'd0);
      chk("rot_bc_clear", 64'(buf_clear), 64'd0);
    end
    req = '0;
    step();
    chk("rot_idle", 64'(so), 64'd0);

    // Reset mid-SEND: U granted from ptr=U, reset, then PE first since ptr returns to PE
    req = 5'b00101; ro = 1'b0;
    sb_q.push_back(mk(2));
    step();
    chk("rm_grant_u", 64'(grant), 64'b00100);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rm_so", 64'(so), 64'd0);
    chk("rm_datao", datao, 64'd0);
    chk("rm_grant", 64'(grant), 64'd0);
    chk("rm_bc", 64'(buf_clear), 64'd0);
`ifdef OUTARB_TIMEOUT_EN
    chk("rm_timeout", 64'(terr), 64'd0);
`endif
    ro = 1'b1;
    sb_q.push_back(mk(0));
    sb_q.push_back(mk(2));
    step();
    chk("rm_regrant_pe", 64'(grant), 64'b00001);
    step();
    chk("rm_bc_pe", 64'(buf_clear), 64'b00001);
    req = 5'b00100;
    step();
    step();
    chk("rm_regrant_u", 64'(grant), 64'b00100);
    chk("rm_datao_u", datao, 64'hA5);
    step();
    chk("rm_bc_u", 64'(buf_clear), 64'b00100);
    req = '0;
    step();

    // U-turn: instance facing U never grants its own direction
    req2 = 5'b00100;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("uturn_so", 64'(so2), 64'd0);
      chk("uturn_grant", 64'(grant2), 64'd0);
    end
    req2 = '0;

    step(); step();
    chk("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
